// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: takes one input vector per valid/ready handshake, holds it,
// and streams it element by element into MLP_layer. Index, value and strobes are
// driven so the layer's synchronous-read weight memories stay aligned with its
// MAC units. The stream pauses and re-fetches while weights are being written.
//
// Handshake: a vector transfers on a cycle where in_valid && in_ready are both
// high. in_ready is high only in IDLE, only while no weight load is in progress,
// and only once the first edge after reset has passed. inputs_flat is captured
// on that edge and is not looked at again for the rest of the run.
module mlp_layer_sequencer #(
  parameter int N_INPUTS = 2,
  parameter int IN_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_INPUTS*IN_WIDTH-1:0]  inputs_flat,
  input  logic                          wgt_wr_en,
  output logic [$clog2(N_INPUTS)-1:0]   input_index,
  output logic signed [IN_WIDTH-1:0]    input_value,
  output logic                          start,
  output logic                          valid,
  output logic                          relu_en,
  output logic                          busy,
  output logic                          out_valid,
  output logic [2:0]                    dbg_state
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ACC   = 3'd2,
    S_RELU  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           i_q, i_d;
  logic                       armed_q;
  logic signed [IN_WIDTH-1:0] x_q [N_INPUTS];
  logic                       accept;

  // A vector is taken only on a completed handshake.
  assign accept = in_valid && in_ready;

  // FSM state, element counter and the post-reset arm flag. The arm flag keeps
  // in_ready low for the cycle right after a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      armed_q <= 1'b1;
    end
  end

  // Capture the whole vector on the accept edge; it is held for the full run.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      for (int j = 0; j < N_INPUTS; j++) begin
        x_q[j] <= inputs_flat[j*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Next state and counter. A write during ACC sends us back to FETCH with i
  // unchanged, because the weight read data was disturbed by the write address.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FETCH;
          i_d     = '0;
        end
      end
      S_FETCH: begin
        if (!wgt_wr_en) state_d = S_ACC;
      end
      S_ACC: begin
        if (wgt_wr_en) begin
          state_d = S_FETCH;
        end else if (i_q == LAST) begin
          state_d = S_RELU;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_RELU:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. In ACC the index runs one ahead so the next weight is
  // already read when the next element is issued; it saturates at the last one.
  always_comb begin
    in_ready    = 1'b0;
    input_index = '0;
    input_value = '0;
    start       = 1'b0;
    valid       = 1'b0;
    relu_en     = 1'b0;
    out_valid   = 1'b0;
    busy        = (state_q != S_IDLE);
    dbg_state   = state_q;
    case (state_q)
      S_IDLE: begin
        in_ready = armed_q && !wgt_wr_en;
      end
      S_FETCH: begin
        input_index = i_q;
      end
      S_ACC: begin
        input_value = x_q[i_q];
        start       = !wgt_wr_en && (i_q == '0);
        valid       = !wgt_wr_en && (i_q != '0);
        input_index = (i_q == LAST) ? LAST : i_q + 1'b1;
      end
      S_RELU: begin
        relu_en = 1'b1;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule
